// File: rtl/modexp_seq.sv
// Sequential modular exponentiator: result = base^expo mod modu.
// Uses right-to-left square-and-multiply. Every modular reduction is
// delegated to an external remainder unit through a toggle/level
// handshake. The dividend is at most 2W bits wide, the divisor is W bits.
// A modulus with the top bit set is rejected. Keeping m below 2^(W-1)
// keeps every product of two residues below 2^(2W-1).

module modexp_seq #(
  parameter int MSB = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               req,
  output logic               ack,
  input  logic [MSB:0]       base,
  input  logic [MSB:0]       expo,
  input  logic [MSB:0]       modu,
  output logic [MSB:0]       result,
  output logic               err,
  output logic [3:0]         cst,
  output logic               rem_req,
  input  logic               rem_ack,
  output logic [2*MSB+1:0]   rem_data_1,
  output logic [MSB:0]       rem_data_2,
  input  logic [MSB:0]       rem_tx_data
);

  localparam int W = MSB + 1;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    LOAD  = 4'd1,
    BASE  = 4'd2,
    CHK   = 4'd3,
    MUL   = 4'd4,
    SQR   = 4'd5,
    ISSUE = 4'd6,
    WLO   = 4'd7,
    WHI   = 4'd8,
    DONE  = 4'd9
  } state_t;

  // Selects which dividend a rem call sends and which register takes the reply.
  typedef enum logic [1:0] {
    OP_BASE = 2'd0,
    OP_MUL  = 2'd1,
    OP_SQR  = 2'd2
  } op_t;

  state_t           state_q, state_n;
  state_t           ret_q,   ret_n;
  op_t              op_q,    op_n;
  logic             req_d,   req_d_n;
  logic             rem_req_n;
  logic [MSB:0]     result_n;
  logic             err_n;
  logic [2*W-1:0]   rem_data_1_n;
  logic [MSB:0]     acc,     acc_n;
  logic [MSB:0]     b,       b_n;
  logic [MSB:0]     e,       e_n;
  logic [MSB:0]     m,       m_n;

  logic [2*W-1:0]   prod_ab;
  logic [2*W-1:0]   prod_bb;
  logic [MSB:0]     e_shr;

  assign ack        = (state_q == IDLE);
  assign cst        = state_q;
  assign rem_data_2 = m;

  // Full-width products. Nothing is truncated before the reduction.
  assign prod_ab = {{W{1'b0}}, acc} * {{W{1'b0}}, b};
  assign prod_bb = {{W{1'b0}}, b}   * {{W{1'b0}}, b};
  assign e_shr   = e >> 1;

  // Next-state and datapath update. Every register holds by default.
  always_comb begin
    state_n      = state_q;
    ret_n        = ret_q;
    op_n         = op_q;
    req_d_n      = req;
    rem_req_n    = rem_req;
    result_n     = result;
    err_n        = err;
    rem_data_1_n = rem_data_1;
    acc_n        = acc;
    b_n          = b;
    e_n          = e;
    m_n          = m;

    case (state_q)
      IDLE: begin
        if (req != req_d) state_n = LOAD;
      end

      LOAD: begin
        m_n   = modu;
        e_n   = expo;
        b_n   = base;
        acc_n = W'(1);
        err_n = 1'b0;
        if ((modu == '0) || modu[MSB]) begin
          err_n    = 1'b1;
          result_n = '0;
          state_n  = IDLE;
        end else if (modu == W'(1)) begin
          result_n = '0;
          state_n  = IDLE;
        end else if (expo == '0) begin
          result_n = W'(1);
          state_n  = IDLE;
        end else begin
          state_n  = BASE;
        end
      end

      // Reduce the raw base once so that every later product stays in range.
      BASE: begin
        op_n    = OP_BASE;
        ret_n   = CHK;
        state_n = ISSUE;
      end

      CHK: begin
        if (e[0]) begin
          state_n = MUL;
        end else begin
          e_n     = e_shr;
          state_n = (e_shr != '0) ? SQR : DONE;
        end
      end

      // The exponent bit has already been consumed, so the shift is done
      // here. The return target then depends on what remains.
      MUL: begin
        op_n    = OP_MUL;
        e_n     = e_shr;
        ret_n   = (e_shr != '0) ? SQR : DONE;
        state_n = ISSUE;
      end

      SQR: begin
        op_n    = OP_SQR;
        ret_n   = CHK;
        state_n = ISSUE;
      end

      ISSUE: begin
        case (op_q)
          OP_MUL:  rem_data_1_n = prod_ab;
          OP_SQR:  rem_data_1_n = prod_bb;
          default: rem_data_1_n = {{W{1'b0}}, b};
        endcase
        rem_req_n = ~rem_req;
        state_n   = WLO;
      end

      // The remainder unit drops ack once it accepts the toggle.
      WLO: begin
        if (!rem_ack) state_n = WHI;
      end

      WHI: begin
        if (rem_ack) begin
          if (op_q == OP_MUL) acc_n = rem_tx_data;
          else                b_n   = rem_tx_data;
          state_n = ret_q;
        end
      end

      DONE: begin
        result_n = acc;
        state_n  = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

  // State register. Reset overrides enable. With enable low, everything freezes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ret_q      <= IDLE;
      op_q       <= OP_BASE;
      req_d      <= 1'b0;
      rem_req    <= 1'b0;
      result     <= '0;
      err        <= 1'b0;
      rem_data_1 <= '0;
      acc        <= '0;
      b          <= '0;
      e          <= '0;
      m          <= '0;
    end else if (enable) begin
      state_q    <= state_n;
      ret_q      <= ret_n;
      op_q       <= op_n;
      req_d      <= req_d_n;
      rem_req    <= rem_req_n;
      result     <= result_n;
      err        <= err_n;
      rem_data_1 <= rem_data_1_n;
      acc        <= acc_n;
      b          <= b_n;
      e          <= e_n;
      m          <= m_n;
    end
  end

endmodule
